// File: rtl/xmul_arb.sv
// xmul_arb: round-robin arbiter sharing one 3-cycle pipelined signed
// multiplier among N_REQ requesters, with a credit-protected result FIFO.

// xmul_pipe: three-register signed multiplier, operands at t -> product at t+3
module xmul_pipe #(
   parameter int DATA_W = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_W-1:0]     a,
   input  logic [DATA_W-1:0]     b,
   output logic [2*DATA_W-1:0]   p
);

   logic signed [DATA_W-1:0]   a_r;
   logic signed [DATA_W-1:0]   b_r;
   logic signed [2*DATA_W-1:0] m_r;

   // operand capture, multiply, output register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_r <= '0;
         b_r <= '0;
         m_r <= '0;
         p   <= '0;
      end else begin
         a_r <= a;
         b_r <= b;
         m_r <= a_r * b_r;
         p   <= m_r;
      end
   end

endmodule

module xmul_arb #(
   parameter int DATA_W     = 32,
   parameter int N_REQ      = 4,
   parameter int FIFO_DEPTH = 5
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         en,
   input  logic [N_REQ-1:0]             req_valid,
   output logic [N_REQ-1:0]             req_ready,
   input  logic [N_REQ*DATA_W-1:0]      req_op_a,
   input  logic [N_REQ*DATA_W-1:0]      req_op_b,
   output logic                         rsp_valid,
   input  logic                         rsp_ready,
   output logic [$clog2(N_REQ)-1:0]     rsp_id,
   output logic [2*DATA_W-1:0]          rsp_product,
   output logic                         busy
);

   localparam int ID_W  = $clog2(N_REQ);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
   localparam int P_W   = 2 * DATA_W;

   logic [ID_W-1:0]   last_grant;
   logic [ID_W-1:0]   grant_id;
   logic              grant;
   logic              credit;
   logic [1:0]        inflight;
   logic [2:0]        tag_v;
   logic [ID_W-1:0]   tag_id [3];
   logic [DATA_W-1:0] mul_a;
   logic [DATA_W-1:0] mul_b;
   logic [P_W-1:0]    mul_p;
   logic [CNT_W-1:0]  fifo_count;
   logic [PTR_W-1:0]  rd_ptr;
   logic [PTR_W-1:0]  wr_ptr;
   logic [P_W-1:0]    mem_p  [FIFO_DEPTH];
   logic [ID_W-1:0]   mem_id [FIFO_DEPTH];
   logic              push;
   logic              pop;

   // credit counts every result already owed to the FIFO, so it can never overflow
   assign inflight = 2'(tag_v[0]) + 2'(tag_v[1]) + 2'(tag_v[2]);
   assign credit   = (32'(fifo_count) + 32'(inflight)) < 32'(FIFO_DEPTH);

   // round-robin search starting just after the last granted requester
   always_comb begin : arb_search
      int unsigned idx;
      idx      = 0;
      grant    = 1'b0;
      grant_id = '0;
      if (rst && en && credit) begin
         for (int unsigned k = 0; k < N_REQ; k++) begin
            idx = 32'(last_grant) + 32'd1 + k;
            if (idx >= 32'(N_REQ)) idx = idx - 32'(N_REQ);
            if (!grant && req_valid[idx[ID_W-1:0]]) begin
               grant    = 1'b1;
               grant_id = idx[ID_W-1:0];
            end
         end
      end
   end

   // one-hot grant and operand mux; idle cycles feed zeros to the multiplier
   always_comb begin
      req_ready = '0;
      mul_a     = '0;
      mul_b     = '0;
      for (int unsigned i = 0; i < N_REQ; i++) begin
         if (grant && grant_id == ID_W'(i)) begin
            req_ready[i] = 1'b1;
            mul_a        = req_op_a[i*DATA_W +: DATA_W];
            mul_b        = req_op_b[i*DATA_W +: DATA_W];
         end
      end
   end

   xmul_pipe #(.DATA_W(DATA_W)) u_mul (
      .clk (clk),
      .rst (~rst),
      .a   (mul_a),
      .b   (mul_b),
      .p   (mul_p)
   );

   // round-robin pointer and tag pipeline shadowing the multiplier
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         last_grant <= ID_W'(N_REQ - 1);
         tag_v      <= '0;
         for (int unsigned s = 0; s < 3; s++) tag_id[s] <= '0;
      end else begin
         if (grant) last_grant <= grant_id;
         tag_v     <= {tag_v[1:0], grant};
         tag_id[0] <= grant_id;
         tag_id[1] <= tag_id[0];
         tag_id[2] <= tag_id[1];
      end
   end

   assign push = tag_v[2];
   assign pop  = rsp_valid && rsp_ready;

   // result FIFO pointers and occupancy; pointers wrap explicitly for any depth
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
      end else begin
         if (push) wr_ptr <= (wr_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= (rd_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
         case ({push, pop})
            2'b10:   fifo_count <= fifo_count + CNT_W'(1);
            2'b01:   fifo_count <= fifo_count - CNT_W'(1);
            default: fifo_count <= fifo_count;
         endcase
      end
   end

   // result storage; contents are only observed while counted as valid
   always_ff @(posedge clk) begin
      if (push) begin
         mem_p[wr_ptr]  <= mul_p;
         mem_id[wr_ptr] <= tag_id[2];
      end
   end

   assign rsp_valid   = (fifo_count != '0);
   assign rsp_id      = rsp_valid ? mem_id[rd_ptr] : '0;
   assign rsp_product = rsp_valid ? mem_p[rd_ptr]  : '0;
   assign busy        = rsp_valid || (tag_v != '0);

endmodule
